// File: rtl/game_input_conditioner.sv
// Button conditioner for the cabinet: sync, debounce, press latching and a
// once-per-frame snapshot into regfile inputs r20 (buttons) and r22 (frame count).
module game_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FRAME_CYCLES    = 833333
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_jump,
  input  logic        btn_duck,
  input  logic        btn_start,
  output logic [31:0] r20,
  output logic [31:0] r22,
  output logic        frame_tick
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(FRAME_CYCLES - 1);

  // Bit 0 jump, bit 1 duck, bit 2 start.
  logic [2:0] raw;
  assign raw = {btn_start, btn_duck, btn_jump};

  logic [2:0]          sync1_q;
  logic [2:0]          sync2_q;
  logic [2:0]          level_q;
  logic [2:0]          level_d;
  logic [2:0][DW-1:0]  cnt_q;
  logic [2:0][DW-1:0]  cnt_d;
  logic [2:0]          latch_q;
  logic [2:0]          latch_d;
  logic [2:0]          rise;
  logic [FW-1:0]       frame_q;
  logic [FW-1:0]       frame_d;
  logic [31:0]         r20_q;
  logic [31:0]         r20_d;
  logic [31:0]         r22_q;
  logic [31:0]         r22_d;
  logic                tick;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        cnt_d[i]   = '0;
        level_d[i] = ~level_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  // A rise is seen in the cycle the level is about to flip, so a flip
  // in the tick cycle is folded straight into that snapshot.
  assign rise = level_d & ~level_q;

  assign tick = (frame_q == FRM_LAST);

  always_comb begin
    frame_d = tick ? '0 : frame_q + FW'(1);
    latch_d = latch_q | rise;
    r20_d   = r20_q;
    r22_d   = r22_q;
    if (tick) begin
      r20_d = {27'd0,
               level_q[2],
               level_q[0],
               latch_q[2] | rise[2],
               level_q[1],
               latch_q[0] | rise[0]};
      r22_d   = r22_q + 32'd1;
      latch_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      latch_q <= '0;
      frame_q <= '0;
      r20_q   <= '0;
      r22_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      frame_q <= frame_d;
      r20_q   <= r20_d;
      r22_q   <= r22_d;
    end
  end

  assign r20        = r20_q;
  assign r22        = r22_q;
  assign frame_tick = tick;

endmodule
